// File: rtl/btn_sw_conditioner_pkg.sv
// Shared types for the switch/button front end: the command encoding
// consumed by the LED logic, button bit positions, and the priority encoder.
package btn_pkg;

    typedef enum logic [2:0] {
        CMD_PASS    = 3'd0,
        CMD_XOR     = 3'd1,
        CMD_ALLONES = 3'd2,
        CMD_SHIFT   = 3'd3,
        CMD_CLEAR   = 3'd4
    } cmd_e;

    localparam int BTN_U = 0;
    localparam int BTN_D = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;

    // Left beats right beats down beats up; with nothing held the LEDs pass through.
    function automatic cmd_e cmd_from_levels(input logic [3:0] levels);
        cmd_e result;
        if (levels[BTN_L]) begin
            result = CMD_XOR;
        end else if (levels[BTN_R]) begin
            result = CMD_ALLONES;
        end else if (levels[BTN_D]) begin
            result = CMD_SHIFT;
        end else if (levels[BTN_U]) begin
            result = CMD_CLEAR;
        end else begin
            result = CMD_PASS;
        end
        return result;
    endfunction

endpackage

// File: rtl/btn_sw_conditioner_if.sv
// Board-side bundle: raw switch/button inputs going in, conditioned
// switch values, button levels/pulses and the LED command coming out.
interface btn_sw_if;
    import btn_pkg::*;

    logic [15:0] sw;
    logic        btnu;
    logic        btnd;
    logic        btnl;
    logic        btnr;
    logic [15:0] sw_sync;
    logic [3:0]  btn_level;
    logic [3:0]  btn_press;
    cmd_e        cmd;

    // The board (or a testbench) drives the raw inputs and watches the results.
    modport master (
        output sw, btnu, btnd, btnl, btnr,
        input  sw_sync, btn_level, btn_press, cmd
    );

    // The conditioner consumes the raw inputs and produces the clean outputs.
    modport slave (
        input  sw, btnu, btnd, btnl, btnr,
        output sw_sync, btn_level, btn_press, cmd
    );

endinterface

// File: rtl/btn_sw_conditioner_debouncer.sv
// One button channel: a synchronizer chain into a stability counter.
// The level only flips after the synchronized input has disagreed with it
// for DEBOUNCE_CYCLES consecutive cycles; a rising flip also emits a pulse.
module debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_count;
    logic                   r_level;
    logic                   r_press;

    logic                   w_stable;
    logic [CNT_W-1:0]       w_countNext;
    logic                   w_levelNext;
    logic                   w_pressNext;

    assign w_stable = r_sync[SYNC_STAGES-1];

    // Shift the raw input through the metastability chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    // Count consecutive disagreeing cycles; flip the level when the count completes.
    always_comb begin
        w_countNext = '0;
        w_levelNext = r_level;
        w_pressNext = 1'b0;
        if (w_stable != r_level) begin
            if (r_count == CNT_MAX) begin
                w_levelNext = w_stable;
                w_pressNext = w_stable;
            end else begin
                w_countNext = r_count + 1'b1;
            end
        end
    end

    // Register the counter, the stable level and its rising-edge pulse together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_count <= w_countNext;
            r_level <= w_levelNext;
            r_press <= w_pressNext;
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/btn_sw_conditioner.sv
// Input front end for the switch/button/LED datapath. Switches are only
// synchronized; the four buttons are synchronized and debounced, and the
// resulting levels are priority-encoded into a registered LED command.
module btn_sw_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic     clk,
    input  logic     rst,
    btn_sw_if.slave  bus
);

    logic [15:0] r_swChain [SYNC_STAGES];
    cmd_e        r_cmd;

    logic [3:0]  w_btnRaw;
    logic [3:0]  w_btnLevel;
    logic [3:0]  w_btnPress;

    assign w_btnRaw[BTN_U] = bus.btnu;
    assign w_btnRaw[BTN_D] = bus.btnd;
    assign w_btnRaw[BTN_L] = bus.btnl;
    assign w_btnRaw[BTN_R] = bus.btnr;

    // Switches change rarely and are read as levels, so a plain synchronizer suffices.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_swChain[i] <= '0;
            end
        end else begin
            r_swChain[0] <= bus.sw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_swChain[i] <= r_swChain[i-1];
            end
        end
    end

    generate
        for (genvar g = 0; g < 4; g++) begin : g_btn
            debouncer #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .SYNC_STAGES     (SYNC_STAGES)
            ) u_debouncer (
                .clk     (clk),
                .rst     (rst),
                .i_raw   (w_btnRaw[g]),
                .o_level (w_btnLevel[g]),
                .o_press (w_btnPress[g])
            );
        end
    endgenerate

    // Register the command one cycle behind the debounced levels so it is glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd <= CMD_PASS;
        end else begin
            r_cmd <= cmd_from_levels(w_btnLevel);
        end
    end

    assign bus.sw_sync   = r_swChain[SYNC_STAGES-1];
    assign bus.btn_level = w_btnLevel;
    assign bus.btn_press = w_btnPress;
    assign bus.cmd       = r_cmd;

endmodule
